rv32i_multicycle_ctrl: RTL

Multi-cycle main controller for the RV32I core. It sequences fetch, decode, execute, memory and writeback over the shared datapath. Per state it drives the 2-bit ALUOp consumed by the ALU control unit, plus datapath enables and muxes. It handshakes with instruction and data memory, and traps illegal opcodes and memory timeouts.

---
 rtl/rv32i_multicycle_ctrl_pkg.sv | 39 +++
 rtl/rv32i_opcode_class.sv | 27 ++
 rtl/rv32i_multicycle_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rv32i_multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, FSM states, classes, mux selects.
// No logic and no latency; backpressure is not applicable to this package.
// Imported by the controller and by the opcode classifier.
package rv32i_multicycle_ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, TRAP
    } state_e;

    typedef enum logic [3:0] {
        CL_R, CL_I, CL_LOAD, CL_STORE, CL_BR,
        CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILLEGAL
    } cls_e;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_R    = 2'b10;
    localparam logic [1:0] ALUOP_I    = 2'b11;

    localparam logic [1:0] PCSEL_PC4  = 2'b00;
    localparam logic [1:0] PCSEL_ALU  = 2'b01;
    localparam logic [1:0] PCSEL_TRAP = 2'b10;

    localparam logic [1:0] WBSEL_ALU  = 2'b00;
    localparam logic [1:0] WBSEL_LOAD = 2'b01;
    localparam logic [1:0] WBSEL_PC4  = 2'b10;
    localparam logic [1:0] WBSEL_IMM  = 2'b11;

endpackage

// File: rtl/rv32i_opcode_class.sv
// Maps the 7-bit major opcode to an instruction class; unknown opcodes map to CL_ILLEGAL.
// Purely combinational, zero latency.
// No backpressure; output follows the input every cycle.
module rv32i_opcode_class
    import rv32i_multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [3:0] cls
);

    always_comb begin
        cls = CL_ILLEGAL;
        case (opcode)
            OP_R:     cls = CL_R;
            OP_I:     cls = CL_I;
            OP_LOAD:  cls = CL_LOAD;
            OP_STORE: cls = CL_STORE;
            OP_BR:    cls = CL_BR;
            OP_JAL:   cls = CL_JAL;
            OP_JALR:  cls = CL_JALR;
            OP_LUI:   cls = CL_LUI;
            OP_AUIPC: cls = CL_AUIPC;
            default:  cls = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I main controller: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencing; PERF_CNT_EN adds cycle/instret counters.
// Zero-wait latency: branch 3 cycles, load 5, all others 4; illegal opcodes trap after DECODE.
// Stalls in FETCH/MEM until imem_ready/dmem_ready; a wait of TIMEOUT cycles traps as a bus error.
module rv32i_multicycle_ctrl
    import rv32i_multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TCNT_W  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        br_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [1:0]  alu_op,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        illegal_insn,
    output logic        bus_err,
    output logic        instret
`ifdef PERF_CNT_EN
    ,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
`endif
);

    localparam bit                TO_EN = (TIMEOUT != 0);
    localparam logic [TCNT_W-1:0] TLIM  = TCNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e            state, nstate;
    cls_e              cls_q, dec_cls;
    logic [3:0]        dec_cls_raw;
    logic [TCNT_W-1:0] wcnt;
    logic              trap_bus;
    logic              timeout_hit;
    logic              instr_unused;

    assign instr_unused = ^instr[31:7];

    rv32i_opcode_class u_cls (
        .opcode (instr[6:0]),
        .cls    (dec_cls_raw)
    );

    assign dec_cls     = cls_e'(dec_cls_raw);
    assign timeout_hit = TO_EN && (wcnt == TLIM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH;
            wcnt     <= '0;
            cls_q    <= CL_ILLEGAL;
            trap_bus <= 1'b0;
        end else begin
            state <= nstate;
            if (state == DECODE)
                cls_q <= dec_cls;
            // Only DECODE traps for an illegal opcode; FETCH/MEM traps are timeouts.
            if (nstate == TRAP)
                trap_bus <= (state != DECODE);
            // Only FETCH and MEM can hold their state, so this counts stalled cycles.
            if (nstate != state)
                wcnt <= '0;
            else
                wcnt <= wcnt + TCNT_W'(1);
        end
    end

    always_comb begin
        nstate       = state;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PCSEL_PC4;
        alu_op       = ALUOP_ADD;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = WBSEL_ALU;
        illegal_insn = 1'b0;
        bus_err      = 1'b0;
        instret      = 1'b0;

        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we  = 1'b1;
                    nstate = DECODE;
                end else if (timeout_hit) begin
                    nstate = TRAP;
                end
            end
            DECODE: begin
                nstate = (dec_cls == CL_ILLEGAL) ? TRAP : EXEC;
            end
            EXEC: begin
                case (cls_q)
                    CL_R: alu_op = ALUOP_R;
                    CL_I: begin
                        alu_op    = ALUOP_I;
                        alu_src_b = 1'b1;
                    end
                    CL_LOAD, CL_STORE, CL_JALR: alu_src_b = 1'b1;
                    CL_BR: begin
                        alu_op  = ALUOP_BR;
                        pc_we   = 1'b1;
                        pc_sel  = br_taken ? PCSEL_ALU : PCSEL_PC4;
                        instret = 1'b1;
                    end
                    CL_JAL, CL_AUIPC: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                    end
                    default: ;
                endcase
                if (cls_q == CL_BR)
                    nstate = FETCH;
                else if (cls_q == CL_LOAD || cls_q == CL_STORE)
                    nstate = MEM;
                else
                    nstate = WB;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == CL_STORE);
                alu_op   = ALUOP_ADD;
                if (dmem_ready) begin
                    if (cls_q == CL_STORE) begin
                        pc_we   = 1'b1;
                        instret = 1'b1;
                        nstate  = FETCH;
                    end else begin
                        nstate  = WB;
                    end
                end else if (timeout_hit) begin
                    nstate = TRAP;
                end
            end
            WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                instret = 1'b1;
                case (cls_q)
                    CL_LOAD: wb_sel = WBSEL_LOAD;
                    CL_JAL, CL_JALR: begin
                        wb_sel = WBSEL_PC4;
                        pc_sel = PCSEL_ALU;
                    end
                    CL_LUI:  wb_sel = WBSEL_IMM;
                    default: ;
                endcase
                nstate = FETCH;
            end
            TRAP: begin
                pc_we        = 1'b1;
                pc_sel       = PCSEL_TRAP;
                illegal_insn = ~trap_bus;
                bus_err      = trap_bus;
                nstate       = FETCH;
            end
            default: nstate = FETCH;
        endcase
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (instret)
                instret_cnt <= instret_cnt + 64'd1;
        end
    end
`endif

endmodule
